// File: rtl/alu_exec_unit.sv
// MIPS execute stage: single-cycle ALU ops plus iterative mult/div into Hi/Lo.
// Optional feature macro: OVERFLOW_TRAP_EN (signed-overflow trap on add/sub).
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_ready,
  input  logic [1:0]       i_alu_op,
  input  logic [5:0]       i_func,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SHW-1:0]   i_shamt,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_valid,
  output logic             o_error,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_ovf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_t;

  state_t           r_state;
  logic             r_ready;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;   // product high half / partial remainder
  logic [WIDTH-1:0] r_sh;    // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] r_opd;   // multiplicand / divisor magnitude
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_valid;
  logic             r_error;
  logic             r_ovf;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_illegal;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_is_signed;
  logic             w_ovf;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

`ifdef OVERFLOW_TRAP_EN
  logic w_add_ovf;
  logic w_sub_ovf;
  assign w_add_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign w_sub_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
`endif

  always_comb begin
    w_res       = '0;
    w_illegal   = 1'b0;
    w_is_mul    = 1'b0;
    w_is_div    = 1'b0;
    w_is_signed = 1'b0;
    w_ovf       = 1'b0;
    case (i_alu_op)
      2'b00: begin
        w_res = w_sum;
`ifdef OVERFLOW_TRAP_EN
        w_ovf = w_add_ovf;
`endif
      end
      2'b01: begin
        w_res = w_diff;
`ifdef OVERFLOW_TRAP_EN
        w_ovf = w_sub_ovf;
`endif
      end
      2'b11: w_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: begin
        case (i_func)
          6'h20: begin
            w_res = w_sum;
`ifdef OVERFLOW_TRAP_EN
            w_ovf = w_add_ovf;
`endif
          end
          6'h21: w_res = w_sum;
          6'h22: begin
            w_res = w_diff;
`ifdef OVERFLOW_TRAP_EN
            w_ovf = w_sub_ovf;
`endif
          end
          6'h23: w_res = w_diff;
          6'h24: w_res = i_a & i_b;
          6'h25: w_res = i_a | i_b;
          6'h26: w_res = i_a ^ i_b;
          6'h27: w_res = ~(i_a | i_b);
          6'h2A: w_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
          6'h2B: w_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
          6'h00: w_res = i_a << i_shamt;
          6'h02: w_res = i_a >> i_shamt;
          6'h03: w_res = $unsigned($signed(i_a) >>> i_shamt);
          6'h10: w_res = r_hi;
          6'h12: w_res = r_lo;
          6'h18: begin w_is_mul = 1'b1; w_is_signed = 1'b1; end
          6'h19: w_is_mul = 1'b1;
          6'h1A: begin w_is_div = 1'b1; w_is_signed = 1'b1; end
          6'h1B: w_is_div = 1'b1;
          default: w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign w_a_neg = w_is_signed & i_a[WIDTH-1];
  assign w_b_neg = w_is_signed & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // One shift-add multiply step on unsigned magnitudes.
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  assign w_mul_sum  = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_opd} : '0);
  assign w_mul_hi   = w_mul_sum[WIDTH:1];
  assign w_mul_lo   = {w_mul_sum[0], r_sh[WIDTH-1:1]};
  assign w_prod     = {w_mul_hi, w_mul_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // One restoring-divide step; a zero divisor naturally yields all-ones quotient.
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_dif;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  assign w_div_sh  = {r_acc, r_sh[WIDTH-1]};
  assign w_div_dif = w_div_sh - {1'b0, r_opd};
  assign w_div_ge  = ~w_div_dif[WIDTH];
  assign w_div_rem = w_div_ge ? w_div_dif[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
  assign w_div_quo = {r_sh[WIDTH-2:0], w_div_ge};
  assign w_quo_fix = r_dz ? '1 : (r_neg_q ? -w_div_quo : w_div_quo);
  assign w_rem_fix = r_neg_r ? -w_div_rem : w_div_rem;

  logic w_last;
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_ready  <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_opd    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_ovf    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      r_ovf   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (w_is_mul || w_is_div) begin
              r_state <= w_is_mul ? StMul : StDiv;
              r_ready <= 1'b0;
              r_cnt   <= '0;
              r_acc   <= '0;
              r_sh    <= w_a_mag;
              r_opd   <= w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_dz    <= (i_b == '0);
            end else begin
              r_valid <= 1'b1;
              r_error <= w_illegal;
              r_ovf   <= w_ovf;
              // Overflow trap suppresses the write; Result/Zero keep old values.
              if (!w_ovf) begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
              end
            end
          end
        end
        StMul: begin
          r_acc <= w_mul_hi;
          r_sh  <= w_mul_lo;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_hi    <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod_fix[WIDTH-1:0];
            r_valid <= 1'b1;
            r_state <= StIdle;
            r_ready <= 1'b1;
          end
        end
        StDiv: begin
          r_acc <= w_div_rem;
          r_sh  <= w_div_quo;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_hi    <= w_rem_fix;
            r_lo    <= w_quo_fix;
            r_valid <= 1'b1;
            r_state <= StIdle;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_result = r_result;
  assign o_zero   = r_zero;
  assign o_valid  = r_valid;
  assign o_error  = r_error;
  assign o_ovf    = r_ovf;
  assign o_hi     = r_hi;
  assign o_lo     = r_lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: per-feature tasks with inline expected values.
module tb_alu_exec_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        o_ready;
  logic [1:0]  i_alu_op = 2'b00;
  logic [5:0]  i_func = 6'h00;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic [4:0]  i_shamt = '0;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_valid;
  logic        o_error;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_ovf;

  int total = 0;
  int bad = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .o_ready(o_ready),
    .i_alu_op(i_alu_op), .i_func(i_func), .i_a(i_a), .i_b(i_b), .i_shamt(i_shamt),
    .o_result(o_result), .o_zero(o_zero), .o_valid(o_valid), .o_error(o_error),
    .o_hi(o_hi), .o_lo(o_lo), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  // Drive one issue cycle starting at a negedge; returns at the following negedge.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    i_start = 1'b1; i_alu_op = op; i_func = fn; i_a = a; i_b = b; i_shamt = sh;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Issue a long op and count negedges until Valid (bounded).
  task automatic run_long(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    issue(2'b10, fn, a, b, 5'd0);
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    total++;
    if ({o_ready, o_zero, o_valid, o_error, o_ovf} !== 5'b11000) begin
      bad++; $display("FAIL reset_flags got=%b exp=11000", {o_ready, o_zero, o_valid, o_error, o_ovf});
    end
    total++;
    if ({o_result, o_hi, o_lo} !== 96'h0) begin
      bad++; $display("FAIL reset_regs got=%h exp=0", {o_result, o_hi, o_lo});
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_slt_back_to_back;
    issue(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1, 5'd0);
    total++;
    if (o_valid !== 1'b1 || o_result !== 32'h1 || o_zero !== 1'b0) begin
      bad++; $display("FAIL slt got v=%b r=%h z=%b exp v=1 r=1 z=0", o_valid, o_result, o_zero);
    end
    issue(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'h1, 5'd0);
    total++;
    if (o_valid !== 1'b1 || o_result !== 32'h0 || o_zero !== 1'b1) begin
      bad++; $display("FAIL sltu got v=%b r=%h z=%b exp v=1 r=0 z=1", o_valid, o_result, o_zero);
    end
    @(negedge i_clk);
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL slt_valid_pulse got=%b exp=0", o_valid);
    end
  endtask

  task automatic test_alu_ops;
    issue(2'b01, 6'h00, 32'd5, 32'd7, 5'd0);
    total++;
    if (o_result !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL sub got=%h exp=fffffffe", o_result);
    end
    issue(2'b10, 6'h27, 32'hF0F0_F0F0, 32'h0F0F_0F00, 5'd0);
    total++;
    if (o_result !== 32'h0000_000F) begin
      bad++; $display("FAIL nor got=%h exp=0000000f", o_result);
    end
    issue(2'b10, 6'h26, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    total++;
    if (o_result !== 32'hF0F0_F0F0) begin
      bad++; $display("FAIL xor got=%h exp=f0f0f0f0", o_result);
    end
    issue(2'b11, 6'h00, 32'h8000_0000, 32'h0, 5'd0);
    total++;
    if (o_result !== 32'h1) begin
      bad++; $display("FAIL slti got=%h exp=1", o_result);
    end
    issue(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'h1, 5'd0);  // leave Result=0 for the mult test
  endtask

  task automatic test_mult;
    int  cyc;
    logic got;
    issue(2'b10, 6'h18, 32'hFFFF_FFFE, 32'd3, 5'd0);
    cyc = 1;
    got = o_valid;
    while (!got && cyc < 100) begin
      if (cyc == 10) begin
        total++;
        if (o_ready !== 1'b0) begin
          bad++; $display("FAIL mult_busy_ready got=%b exp=0", o_ready);
        end
        i_alu_op = 2'b00; i_a = 32'd5; i_b = 32'd5; i_start = 1'b1;
      end
      @(negedge i_clk);
      i_start = 1'b0;
      cyc++;
      got = o_valid;
    end
    total++;
    if (cyc !== 33) begin
      bad++; $display("FAIL mult_latency got=%0d exp=33", cyc);
    end
    total++;
    if (o_hi !== 32'hFFFF_FFFF || o_lo !== 32'hFFFF_FFFA) begin
      bad++; $display("FAIL mult_hilo got=%h_%h exp=ffffffff_fffffffa", o_hi, o_lo);
    end
    total++;
    if (o_result !== 32'h0 || o_zero !== 1'b1 || o_ready !== 1'b1 || o_error !== 1'b0) begin
      bad++; $display("FAIL mult_side got r=%h z=%b rdy=%b e=%b exp r=0 z=1 rdy=1 e=0",
                      o_result, o_zero, o_ready, o_error);
    end
    @(negedge i_clk);
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL mult_valid_pulse got=%b exp=0", o_valid);
    end
  endtask

  task automatic test_div;
    int cyc;
    run_long(6'h1A, 32'hFFFF_FFF9, 32'd2, cyc);
    total++;
    if (cyc !== 33 || o_lo !== 32'hFFFF_FFFD || o_hi !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL div_neg got cyc=%0d lo=%h hi=%h exp cyc=33 lo=fffffffd hi=ffffffff",
                      cyc, o_lo, o_hi);
    end
    @(negedge i_clk);
    run_long(6'h1B, 32'h1234_5678, 32'd0, cyc);
    total++;
    if (cyc !== 33 || o_lo !== 32'hFFFF_FFFF || o_hi !== 32'h1234_5678 || o_error !== 1'b0) begin
      bad++; $display("FAIL divu_zero got cyc=%0d lo=%h hi=%h e=%b exp cyc=33 lo=ffffffff hi=12345678 e=0",
                      cyc, o_lo, o_hi, o_error);
    end
    @(negedge i_clk);
    issue(2'b10, 6'h10, 32'h0, 32'h0, 5'd0);
    total++;
    if (o_result !== 32'h1234_5678) begin
      bad++; $display("FAIL mfhi got=%h exp=12345678", o_result);
    end
    issue(2'b10, 6'h12, 32'h0, 32'h0, 5'd0);
    total++;
    if (o_result !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mflo got=%h exp=ffffffff", o_result);
    end
    run_long(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    total++;
    if (o_lo !== 32'h8000_0000 || o_hi !== 32'h0) begin
      bad++; $display("FAIL div_minneg got lo=%h hi=%h exp lo=80000000 hi=0", o_lo, o_hi);
    end
    @(negedge i_clk);
    run_long(6'h1A, 32'd7, 32'hFFFF_FFFE, cyc);
    total++;
    if (o_lo !== 32'hFFFF_FFFD || o_hi !== 32'h1) begin
      bad++; $display("FAIL div_negb got lo=%h hi=%h exp lo=fffffffd hi=1", o_lo, o_hi);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_op;
    logic seen;
    issue(2'b10, 6'h19, 32'd2, 32'd3, 5'd0);
    repeat (4) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_ready !== 1'b1 || o_hi !== 32'h0 || o_lo !== 32'h0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid got rdy=%b hi=%h lo=%h v=%b exp rdy=1 hi=0 lo=0 v=0",
                      o_ready, o_hi, o_lo, o_valid);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || o_lo !== 32'h0) begin
      bad++; $display("FAIL reset_abort got valid_seen=%b lo=%h exp 0 0", seen, o_lo);
    end
  endtask

  task automatic test_shift_illegal;
    issue(2'b10, 6'h03, 32'h8000_0000, 32'h0, 5'd4);
    total++;
    if (o_result !== 32'hF800_0000) begin
      bad++; $display("FAIL sra got=%h exp=f8000000", o_result);
    end
    issue(2'b10, 6'h02, 32'h8000_0000, 32'h0, 5'd4);
    total++;
    if (o_result !== 32'h0800_0000) begin
      bad++; $display("FAIL srl got=%h exp=08000000", o_result);
    end
    issue(2'b10, 6'h00, 32'h1, 32'h0, 5'd31);
    total++;
    if (o_result !== 32'h8000_0000) begin
      bad++; $display("FAIL sll got=%h exp=80000000", o_result);
    end
    issue(2'b10, 6'h3F, 32'h1, 32'h2, 5'd0);
    total++;
    if (o_valid !== 1'b1 || o_error !== 1'b1 || o_result !== 32'h0 || o_zero !== 1'b1) begin
      bad++; $display("FAIL illegal got v=%b e=%b r=%h z=%b exp v=1 e=1 r=0 z=1",
                      o_valid, o_error, o_result, o_zero);
    end
    @(negedge i_clk);
    total++;
    if (o_error !== 1'b0) begin
      bad++; $display("FAIL error_pulse got=%b exp=0", o_error);
    end
  endtask

  task automatic test_overflow;
    issue(2'b00, 6'h00, 32'd3, 32'd4, 5'd0);
    total++;
    if (o_result !== 32'd7) begin
      bad++; $display("FAIL add got=%h exp=7", o_result);
    end
    issue(2'b10, 6'h20, 32'h7FFF_FFFF, 32'h1, 5'd0);
`ifdef OVERFLOW_TRAP_EN
    total++;
    if (o_valid !== 1'b1 || o_ovf !== 1'b1 || o_result !== 32'd7) begin
      bad++; $display("FAIL add_ovf got v=%b o=%b r=%h exp v=1 o=1 r=7", o_valid, o_ovf, o_result);
    end
`else
    total++;
    if (o_valid !== 1'b1 || o_ovf !== 1'b0 || o_result !== 32'h8000_0000) begin
      bad++; $display("FAIL add_wrap got v=%b o=%b r=%h exp v=1 o=0 r=80000000",
                      o_valid, o_ovf, o_result);
    end
`endif
    issue(2'b10, 6'h21, 32'h7FFF_FFFF, 32'h1, 5'd0);
    total++;
    if (o_ovf !== 1'b0 || o_result !== 32'h8000_0000) begin
      bad++; $display("FAIL addu got o=%b r=%h exp o=0 r=80000000", o_ovf, o_result);
    end
  endtask

  initial begin
    test_reset;
    test_slt_back_to_back;
    test_alu_ops;
    test_mult;
    test_div;
    test_reset_mid_op;
    test_shift_illegal;
    test_overflow;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
